datapath_sequencer: RTL and testbench
=====================================

// Module: datapath_sequencer
// PURPOSE
//  Sequences the register-file/ALU datapath from a stream of 32-bit instruction words.
//  - Accepts one instruction per valid/ready handshake.
//  - Decodes it into the datapath control word: FS, AA, BA, DA, K, Bselect, cin, write, EN_B, EN_ALU.
//  - Runs the operand-setup, execute and writeback phases, including multi-cycle repeat ops.
//  - Sits between the instruction source (bench or future fetch unit) and the datapath.
// PARAMETERS
//  IMM_W   10  immediate field width; zero-extended onto K
//  K_W     64  constant (K) bus width into the datapath
// PORTS
//  clock        in   1    single clock; all state updates on posedge
//  reset        in   1    synchronous, active-low
//  instr        in   32   [31:30] op, [29:25] FS, [24:20] DA, [19:15] AA, [14:10] BA, [9:0] imm
//  instr_valid  in   1    instr is presented
//  instr_ready  out  1    sequencer can accept
//  done         out  1    one-cycle pulse: instruction retired
//  err          out  1    one-cycle pulse with done: write suppressed (DP_SEQ_R0_PROTECT_EN only)
//  FS           out  5    ALU function select
//  AA, BA, DA   out  5    register-file A, B and destination addresses
//  K            out  K_W  constant = zero-extended imm
//  Bselect      out  1    1: B operand = K; 0: B operand = regfile B
//  cin          out  1    ALU carry-in
//  write        out  1    register-file write enable
//  EN_B, EN_ALU out  1    bus tri-state enables; never both 1
// BEHAVIOUR
//  Ops: 00 ALU_RR (Bselect=0, cin=imm[0]); 01 ALU_RI (Bselect=1, K=imm, cin=0);
//       10 MOVE (EN_B=1, EN_ALU=0, DA<=B bus); 11 REPEAT (AA=DA=instr DA, Bselect=1, K=0).
//  REPEAT iteration count n = imm[4:0]+1 (1..32); an imm of 0 gives one iteration.
//  FSM states: IDLE -> SETUP -> EXEC -> DONE -> IDLE.
//  - IDLE: instr_ready=1; on valid&&ready, latch instr and go to SETUP.
//  - SETUP: one cycle; addresses, FS, K and Bselect driven; write=0.
//  - EXEC: write=1. Stays 1 cycle for ops 00..10. For REPEAT, stays n cycles with write=1
//    each cycle; a down-counter loaded with n-1 in SETUP; exit when counter==0.
//  - DONE: done=1, write=0, instr_ready=0; next state is IDLE.
//  Latency (cycles after the accepting edge): SETUP at +1, EXEC at +2, done at +3. REPEAT: done at +2+n.
//  Control outputs are registered. Latched fields hold from SETUP through DONE.
//  Outside EXEC/DONE: write=0. In IDLE: EN_ALU=1, EN_B=0, so the bus is always driven.
//  Reset (reset==0 at posedge): state=IDLE, counter=0.
//  - Outputs after reset: instr_ready=0, done=0, err=0, write=0, FS/AA/BA/DA/K=0,
//    Bselect=0, cin=0, EN_B=0, EN_ALU=1.
//  - instr_ready rises on the first edge with reset==1.
//  - Reset mid-EXEC aborts: write=0 on the same edge, no done pulse.
//  instr_valid while busy is ignored; the source must hold the word until the handshake.
//  instr_valid dropping after acceptance has no effect.
// CONFIGURATION
//  Macro DP_SEQ_R0_PROTECT_EN.
//  - Defined: any op with DA==0 runs SETUP/EXEC with write forced 0, and pulses err together with done.
//  - Undefined: r0 is written like any register; err is tied 0.
// STRUCTURE
//  Package dp_seq_pkg:
//  - op encodings (OP_ALU_RR, OP_ALU_RI, OP_MOVE, OP_REPEAT)
//  - state encodings
//  - instr field bit positions
//  - IMM_W and K_W defaults
//  Sub-module dp_seq_decode: combinational; latched instr -> control word (FS, AA, BA, DA, K,
//  Bselect, cin, EN_B, EN_ALU, n). The top level holds the FSM, counter and handshake.
// TESTING
//  1. Reset low 2 cycles, then high -> all outputs at reset values; instr_ready=1 one cycle after release.
//  2. ALU_RR FS=5'h02 DA=3 AA=1 BA=2 imm[0]=1 -> SETUP at +1; write=1, Bselect=0, cin=1 at +2; done at +3.
//  3. ALU_RI DA=4 AA=4 imm=10'd37 -> K=64'd37, Bselect=1 in SETUP/EXEC; single write; done at +3.
//  4. MOVE DA=7 BA=5 -> EN_B=1, EN_ALU=0 only in SETUP/EXEC; never EN_B&EN_ALU; EN_ALU=1 back in IDLE.
//  5. REPEAT imm=5'd3 -> write=1 for exactly 4 cycles; done at +6; then imm=0 -> exactly 1 write cycle.
//  6. REPEAT imm=31, reset low at 2nd EXEC cycle -> write=0 next edge, no done, IDLE. With the macro, DA=0 -> no write, err=done=1.

Source files
------------

// File: rtl/dp_seq_pkg.sv
// Shared types and constants for the datapath sequencer: op and state encodings,
// instruction field positions, parameter defaults and the registered control word.
package dp_seq_pkg;

  localparam int unsigned INSTR_W       = 32;
  localparam int unsigned IMM_W_DEFAULT = 10;
  localparam int unsigned K_W_DEFAULT   = 64;
  localparam int unsigned REG_AW        = 5;
  localparam int unsigned CNT_W         = 5;

  // Instruction field LSB positions: [31:30] op, [29:25] FS, [24:20] DA, [19:15] AA,
  // [14:10] BA, [9:0] imm.
  localparam int unsigned OP_LSB  = 30;
  localparam int unsigned FS_LSB  = 25;
  localparam int unsigned DA_LSB  = 20;
  localparam int unsigned AA_LSB  = 15;
  localparam int unsigned BA_LSB  = 10;
  localparam int unsigned IMM_LSB = 0;

  typedef enum logic [1:0] {
    OP_ALU_RR = 2'b00,
    OP_ALU_RI = 2'b01,
    OP_MOVE   = 2'b10,
    OP_REPEAT = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    StIdle  = 2'b00,
    StSetup = 2'b01,
    StExec  = 2'b10,
    StDone  = 2'b11
  } state_e;

  // Registered control/handshake outputs, minus the parameter-width K bus.
  typedef struct packed {
    logic [REG_AW-1:0] fs;
    logic [REG_AW-1:0] aa;
    logic [REG_AW-1:0] ba;
    logic [REG_AW-1:0] da;
    logic              bselect;
    logic              cin;
    logic              write;
    logic              en_b;
    logic              en_alu;
    logic              ready;
    logic              done;
    logic              err;
  } ctrl_t;

  // Bus stays driven by the ALU whenever nothing is being sequenced.
  localparam ctrl_t CtrlReset = '{
    fs: '0, aa: '0, ba: '0, da: '0,
    bselect: 1'b0, cin: 1'b0, write: 1'b0,
    en_b: 1'b0, en_alu: 1'b1,
    ready: 1'b0, done: 1'b0, err: 1'b0
  };

  // REPEAT iteration count: a 5-bit field of 0..31 maps to 1..32 iterations.
  function automatic logic [CNT_W:0] repeat_count(input logic [CNT_W-1:0] field);
    return {1'b0, field} + {{CNT_W{1'b0}}, 1'b1};
  endfunction

endpackage

// File: rtl/dp_seq_decode.sv
// Combinational decode of a latched instruction word into the datapath control word
// and the execute-phase iteration count.
module dp_seq_decode
  import dp_seq_pkg::*;
#(
  parameter int unsigned IMM_W = IMM_W_DEFAULT,
  parameter int unsigned K_W   = K_W_DEFAULT
) (
  input  logic [INSTR_W-1:0] instr_i,
  output logic [REG_AW-1:0]  fs_o,
  output logic [REG_AW-1:0]  aa_o,
  output logic [REG_AW-1:0]  ba_o,
  output logic [REG_AW-1:0]  da_o,
  output logic [K_W-1:0]     k_o,
  output logic               bselect_o,
  output logic               cin_o,
  output logic               en_b_o,
  output logic               en_alu_o,
  output logic [CNT_W:0]     n_o
);

  op_e              op;
  logic [IMM_W-1:0] imm;

  assign op  = op_e'(instr_i[OP_LSB +: 2]);
  assign imm = instr_i[IMM_LSB +: IMM_W];

  // Field pass-through by default; each op overrides only what it changes.
  always_comb begin
    fs_o      = instr_i[FS_LSB +: REG_AW];
    aa_o      = instr_i[AA_LSB +: REG_AW];
    ba_o      = instr_i[BA_LSB +: REG_AW];
    da_o      = instr_i[DA_LSB +: REG_AW];
    k_o       = K_W'(imm);
    bselect_o = 1'b0;
    cin_o     = 1'b0;
    en_b_o    = 1'b0;
    en_alu_o  = 1'b1;
    n_o       = repeat_count('0);
    unique case (op)
      OP_ALU_RR: cin_o = imm[0];
      OP_ALU_RI: bselect_o = 1'b1;
      OP_MOVE: begin
        en_b_o   = 1'b1;
        en_alu_o = 1'b0;
      end
      OP_REPEAT: begin
        // Read-modify-write of the same register with a zero constant on B.
        aa_o      = instr_i[DA_LSB +: REG_AW];
        bselect_o = 1'b1;
        k_o       = '0;
        n_o       = repeat_count(imm[CNT_W-1:0]);
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/datapath_sequencer.sv
// Datapath sequencer: accepts one instruction per valid/ready handshake and steps it
// through SETUP, EXEC (1 or n cycles) and DONE, driving a registered control word.
// Optional macro DP_SEQ_R0_PROTECT_EN: suppress writes to r0 and flag them on err.
module datapath_sequencer
  import dp_seq_pkg::*;
#(
  parameter int unsigned IMM_W = IMM_W_DEFAULT,
  parameter int unsigned K_W   = K_W_DEFAULT
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [INSTR_W-1:0] instr,
  input  logic               instr_valid,
  output logic               instr_ready,
  output logic               done,
  output logic               err,
  output logic [REG_AW-1:0]  FS,
  output logic [REG_AW-1:0]  AA,
  output logic [REG_AW-1:0]  BA,
  output logic [REG_AW-1:0]  DA,
  output logic [K_W-1:0]     K,
  output logic               Bselect,
  output logic               cin,
  output logic               write,
  output logic               EN_B,
  output logic               EN_ALU
);

  state_e             state_q, state_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  ctrl_t              ctrl_q, ctrl_d;
  logic [K_W-1:0]     k_q, k_d;

  logic [REG_AW-1:0]  dec_fs, dec_aa, dec_ba, dec_da;
  logic [K_W-1:0]     dec_k;
  logic               dec_bselect, dec_cin, dec_en_b, dec_en_alu;
  logic [CNT_W:0]     dec_n;
  logic               wr_allow;

  // Decode the word that will be held after this edge so outputs can be registered.
  dp_seq_decode #(
    .IMM_W (IMM_W),
    .K_W   (K_W)
  ) u_decode (
    .instr_i   (instr_d),
    .fs_o      (dec_fs),
    .aa_o      (dec_aa),
    .ba_o      (dec_ba),
    .da_o      (dec_da),
    .k_o       (dec_k),
    .bselect_o (dec_bselect),
    .cin_o     (dec_cin),
    .en_b_o    (dec_en_b),
    .en_alu_o  (dec_en_alu),
    .n_o       (dec_n)
  );

`ifdef DP_SEQ_R0_PROTECT_EN
  assign wr_allow = (dec_da != '0);
`else
  assign wr_allow = 1'b1;
`endif

  // Next state, instruction latch and repeat down-counter.
  always_comb begin
    state_d = state_q;
    instr_d = instr_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (instr_valid && ctrl_q.ready) begin
          state_d = StSetup;
          instr_d = instr;
        end
      end
      StSetup: begin
        state_d = StExec;
        cnt_d   = CNT_W'(dec_n - (CNT_W + 1)'(1));
      end
      StExec: begin
        if (cnt_q == '0) begin
          state_d = StDone;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Control word for the state entered on this edge.
  always_comb begin
    ctrl_d = CtrlReset;
    k_d    = '0;
    unique case (state_d)
      StIdle: ctrl_d.ready = 1'b1;
      StSetup, StExec, StDone: begin
        ctrl_d.fs      = dec_fs;
        ctrl_d.aa      = dec_aa;
        ctrl_d.ba      = dec_ba;
        ctrl_d.da      = dec_da;
        ctrl_d.bselect = dec_bselect;
        ctrl_d.cin     = dec_cin;
        k_d            = dec_k;
        if (state_d != StDone) begin
          ctrl_d.en_b   = dec_en_b;
          ctrl_d.en_alu = dec_en_alu;
        end
        if (state_d == StExec) begin
          ctrl_d.write = wr_allow;
        end
        if (state_d == StDone) begin
          ctrl_d.done = 1'b1;
          ctrl_d.err  = ~wr_allow;
        end
      end
      default: ;
    endcase
  end

  // State and registered outputs; synchronous active-low reset aborts any instruction.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= StIdle;
      instr_q <= '0;
      cnt_q   <= '0;
      ctrl_q  <= CtrlReset;
      k_q     <= '0;
    end else begin
      state_q <= state_d;
      instr_q <= instr_d;
      cnt_q   <= cnt_d;
      ctrl_q  <= ctrl_d;
      k_q     <= k_d;
    end
  end

  assign instr_ready = ctrl_q.ready;
  assign done        = ctrl_q.done;
  assign err         = ctrl_q.err;
  assign FS          = ctrl_q.fs;
  assign AA          = ctrl_q.aa;
  assign BA          = ctrl_q.ba;
  assign DA          = ctrl_q.da;
  assign K           = k_q;
  assign Bselect     = ctrl_q.bselect;
  assign cin         = ctrl_q.cin;
  assign write       = ctrl_q.write;
  assign EN_B        = ctrl_q.en_b;
  assign EN_ALU      = ctrl_q.en_alu;

endmodule

// File: tb/tb_datapath_sequencer.sv
// Self-checking bench for datapath_sequencer: directed instructions, expected control
// words and timing queued at issue and compared as the sequencer steps through them.
module tb_datapath_sequencer;

  logic        clock;
  logic        reset;
  logic [31:0] instr;
  logic        instr_valid;
  logic        instr_ready;
  logic        done;
  logic        err;
  logic [4:0]  FS, AA, BA, DA;
  logic [63:0] K;
  logic        Bselect, cin, write, EN_B, EN_ALU;

  typedef struct {
    logic [4:0]  fs, aa, ba, da;
    logic [63:0] k;
    logic        bsel, cin, en_b, en_alu, err;
    int          writes;
    int          lat;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  datapath_sequencer dut (
    .clock       (clock),
    .reset       (reset),
    .instr       (instr),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .done        (done),
    .err         (err),
    .FS          (FS),
    .AA          (AA),
    .BA          (BA),
    .DA          (DA),
    .K           (K),
    .Bselect     (Bselect),
    .cin         (cin),
    .write       (write),
    .EN_B        (EN_B),
    .EN_ALU      (EN_ALU)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  function automatic logic [31:0] mk(input logic [1:0] op, input logic [4:0] fs,
                                     input logic [4:0] da, input logic [4:0] aa,
                                     input logic [4:0] ba, input logic [9:0] imm);
    return {op, fs, da, aa, ba, imm};
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Wait (bounded) for ready, present the word for exactly the accepting edge.
  task automatic issue(input logic [31:0] w);
    int n;
    n = 0;
    @(negedge clock);
    while (!instr_ready && n < 20) begin
      @(negedge clock);
      n++;
    end
    chk("ready_before_issue", 64'(instr_ready), 64'd1);
    instr       = w;
    instr_valid = 1'b1;
    @(posedge clock);
    #1;
    instr_valid = 1'b0;
    instr       = '0;
  endtask

  // Follow one instruction from the cycle after acceptance through the return to idle.
  task automatic observe(input string nm);
    exp_t e;
    int   writes;
    int   lat;
    bit   conflict;
    e        = sb.pop_front();
    writes   = 0;
    lat      = 0;
    conflict = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clock);
      if (EN_B && EN_ALU) conflict = 1'b1;
      if (write) writes++;
      if (k == 1) begin
        chk({nm, ".setup_write"}, 64'(write), 64'd0);
        chk({nm, ".setup_ready"}, 64'(instr_ready), 64'd0);
        chk({nm, ".FS"}, 64'(FS), 64'(e.fs));
        chk({nm, ".AA"}, 64'(AA), 64'(e.aa));
        chk({nm, ".BA"}, 64'(BA), 64'(e.ba));
        chk({nm, ".DA"}, 64'(DA), 64'(e.da));
        chk({nm, ".K"}, K, e.k);
        chk({nm, ".Bselect"}, 64'(Bselect), 64'(e.bsel));
        chk({nm, ".cin"}, 64'(cin), 64'(e.cin));
        chk({nm, ".setup_EN_B"}, 64'(EN_B), 64'(e.en_b));
        chk({nm, ".setup_EN_ALU"}, 64'(EN_ALU), 64'(e.en_alu));
      end
      if (k == 2) begin
        chk({nm, ".exec_write"}, 64'(write), 64'(e.writes != 0));
        chk({nm, ".exec_K"}, K, e.k);
        chk({nm, ".exec_Bselect"}, 64'(Bselect), 64'(e.bsel));
        chk({nm, ".exec_EN_B"}, 64'(EN_B), 64'(e.en_b));
        chk({nm, ".exec_EN_ALU"}, 64'(EN_ALU), 64'(e.en_alu));
      end
      if (done) begin
        lat = k;
        chk({nm, ".done_err"}, 64'(err), 64'(e.err));
        chk({nm, ".done_write"}, 64'(write), 64'd0);
        chk({nm, ".done_ready"}, 64'(instr_ready), 64'd0);
        chk({nm, ".done_DA_hold"}, 64'(DA), 64'(e.da));
        break;
      end
    end
    chk({nm, ".done_latency"}, 64'(lat), 64'(e.lat));
    chk({nm, ".write_cycles"}, 64'(writes), 64'(e.writes));
    chk({nm, ".bus_exclusive"}, 64'(conflict), 64'd0);
    @(negedge clock);
    chk({nm, ".idle_ready"}, 64'(instr_ready), 64'd1);
    chk({nm, ".idle_EN_ALU"}, 64'(EN_ALU), 64'd1);
    chk({nm, ".idle_EN_B"}, 64'(EN_B), 64'd0);
    chk({nm, ".idle_write"}, 64'(write), 64'd0);
    chk({nm, ".idle_done"}, 64'(done), 64'd0);
  endtask

  initial begin
    bit saw_done;
    reset       = 1'b0;
    instr       = '0;
    instr_valid = 1'b0;

    // Reset held low for two edges.
    repeat (2) @(posedge clock);
    @(negedge clock);
    chk("rst.instr_ready", 64'(instr_ready), 64'd0);
    chk("rst.done", 64'(done), 64'd0);
    chk("rst.err", 64'(err), 64'd0);
    chk("rst.write", 64'(write), 64'd0);
    chk("rst.FS", 64'(FS), 64'd0);
    chk("rst.AA", 64'(AA), 64'd0);
    chk("rst.BA", 64'(BA), 64'd0);
    chk("rst.DA", 64'(DA), 64'd0);
    chk("rst.K", K, 64'd0);
    chk("rst.Bselect", 64'(Bselect), 64'd0);
    chk("rst.cin", 64'(cin), 64'd0);
    chk("rst.EN_B", 64'(EN_B), 64'd0);
    chk("rst.EN_ALU", 64'(EN_ALU), 64'd1);
    reset = 1'b1;
    @(negedge clock);
    chk("rst.ready_after_release", 64'(instr_ready), 64'd1);

    // ALU register-register, carry-in from imm[0].
    sb.push_back('{fs: 5'h02, aa: 5'd1, ba: 5'd2, da: 5'd3, k: 64'd1, bsel: 1'b0, cin: 1'b1,
                   en_b: 1'b0, en_alu: 1'b1, err: 1'b0, writes: 1, lat: 3});
    issue(mk(2'b00, 5'h02, 5'd3, 5'd1, 5'd2, 10'd1));
    observe("alu_rr");

    // ALU register-immediate; imm[0]=1 must not reach cin.
    sb.push_back('{fs: 5'h02, aa: 5'd4, ba: 5'd0, da: 5'd4, k: 64'd37, bsel: 1'b1, cin: 1'b0,
                   en_b: 1'b0, en_alu: 1'b1, err: 1'b0, writes: 1, lat: 3});
    issue(mk(2'b01, 5'h02, 5'd4, 5'd4, 5'd0, 10'd37));
    observe("alu_ri");

    // Move: B bus drives the destination.
    sb.push_back('{fs: 5'h00, aa: 5'd0, ba: 5'd5, da: 5'd7, k: 64'd0, bsel: 1'b0, cin: 1'b0,
                   en_b: 1'b1, en_alu: 1'b0, err: 1'b0, writes: 1, lat: 3});
    issue(mk(2'b10, 5'h00, 5'd7, 5'd0, 5'd5, 10'd0));
    observe("move");

    // Repeat 4 times; AA field (2) is replaced by DA.
    sb.push_back('{fs: 5'h01, aa: 5'd6, ba: 5'd0, da: 5'd6, k: 64'd0, bsel: 1'b1, cin: 1'b0,
                   en_b: 1'b0, en_alu: 1'b1, err: 1'b0, writes: 4, lat: 6});
    issue(mk(2'b11, 5'h01, 5'd6, 5'd2, 5'd0, 10'd3));
    observe("repeat4");

    // Repeat with imm 0: single iteration.
    sb.push_back('{fs: 5'h01, aa: 5'd9, ba: 5'd0, da: 5'd9, k: 64'd0, bsel: 1'b1, cin: 1'b0,
                   en_b: 1'b0, en_alu: 1'b1, err: 1'b0, writes: 1, lat: 3});
    issue(mk(2'b11, 5'h01, 5'd9, 5'd9, 5'd0, 10'd0));
    observe("repeat1");

    // Repeat at maximum count: 32 iterations.
    sb.push_back('{fs: 5'h01, aa: 5'd8, ba: 5'd0, da: 5'd8, k: 64'd0, bsel: 1'b1, cin: 1'b0,
                   en_b: 1'b0, en_alu: 1'b1, err: 1'b0, writes: 32, lat: 34});
    issue(mk(2'b11, 5'h01, 5'd8, 5'd8, 5'd0, 10'd31));
    observe("repeat32");

    // Destination r0.
`ifdef DP_SEQ_R0_PROTECT_EN
    sb.push_back('{fs: 5'h02, aa: 5'd1, ba: 5'd0, da: 5'd0, k: 64'd5, bsel: 1'b1, cin: 1'b0,
                   en_b: 1'b0, en_alu: 1'b1, err: 1'b1, writes: 0, lat: 3});
`else
    sb.push_back('{fs: 5'h02, aa: 5'd1, ba: 5'd0, da: 5'd0, k: 64'd5, bsel: 1'b1, cin: 1'b0,
                   en_b: 1'b0, en_alu: 1'b1, err: 1'b0, writes: 1, lat: 3});
`endif
    issue(mk(2'b01, 5'h02, 5'd0, 5'd1, 5'd0, 10'd5));
    observe("r0_dest");

    // Reset during the second EXEC cycle of a long repeat aborts it.
    issue(mk(2'b11, 5'h01, 5'd6, 5'd6, 5'd0, 10'd31));
    @(negedge clock);
    @(negedge clock);
    chk("abort.exec1_write", 64'(write), 64'd1);
    @(negedge clock);
    chk("abort.exec2_write", 64'(write), 64'd1);
    reset = 1'b0;
    @(negedge clock);
    chk("abort.write", 64'(write), 64'd0);
    chk("abort.done", 64'(done), 64'd0);
    chk("abort.ready", 64'(instr_ready), 64'd0);
    chk("abort.EN_ALU", 64'(EN_ALU), 64'd1);
    reset    = 1'b1;
    saw_done = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      if (done || write) saw_done = 1'b1;
    end
    chk("abort.no_done_or_write", 64'(saw_done), 64'd0);
    chk("abort.idle_ready", 64'(instr_ready), 64'd1);
    chk("abort.sb_empty", 64'(sb.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
